psum_drain_arbiter: RTL
=======================

Name: psum_drain_arbiter

Overview:
- Drains the per-column psum output streams of one PE cluster into the single psum GLB write port.
- Arbitrates round-robin between columns, granting each column a fixed burst of beats.
- Generates a per-column GLB write address for every beat.
- Sits between the cluster's psum_data_out_packed / psum_out_cluster_enables / psum_out_cluster_readys and the psum GLB bank.

Parameters:
COLS, `HWC_PE_CLUSTER_COLS (4), number of psum columns arbitrated
DATA_WIDTH, `HWC_PSUM_BUFFER_WIDTH*`HWC_SIMD, width of one psum beat
BURST_WIDTH, 8, width of burst length and burst count configs
ADDR_WIDTH, 10, GLB psum address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  clock-gating enable; when low, all state holds and no handshake completes
conf_en  in  1  latch configuration; honoured in IDLE only
col_mask  in  COLS  columns taking part in the drain
burst_len  in  BURST_WIDTH  beats per grant (M0)
bursts_per_col  in  BURST_WIDTH  grants each enabled column receives
base_addr_packed  in  COLS*ADDR_WIDTH  per-column start address, column c at [(c+1)*ADDR_WIDTH-1 -: ADDR_WIDTH]
psum_valid_in  in  COLS  column psum valid (cluster psum_out_cluster_enables)
psum_data_in_packed  in  COLS*DATA_WIDTH  column psum data
psum_ready_out  out  COLS  column ready (cluster psum_out_cluster_readys)
glb_wr_en  out  1  registered write valid
glb_wr_addr  out  ADDR_WIDTH  registered write address
glb_wr_data  out  DATA_WIDTH  registered write data
glb_wr_ready  in  1  GLB accepts the write
grant_col  out  $clog2(COLS)  currently granted column
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse when the drain completes
perf_stall_cnt  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; address counters 0; beat and burst counters 0.
- States:
  - IDLE: on conf_en, latch all config inputs and set addr[c]=base[c] and remaining[c]=bursts_per_col for every c in col_mask.
    - If col_mask==0, burst_len==0 or bursts_per_col==0, go to FIN.
    - Otherwise go to PICK.
  - PICK (1 cycle): choose the first column with remaining[c]!=0, searching from rr_ptr+1 with wrap, where rr_ptr is the last granted column. Set grant_col, clear beat_cnt, go to BURST.
  - BURST:
    - psum_ready_out[grant_col] = stage_free; all other ready bits are 0. stage_free = !glb_wr_en || glb_wr_ready.
    - A beat transfers when valid[grant_col] && ready. On transfer: load the output stage with the data and addr[grant_col], then increment addr[grant_col] (wraps modulo 2^ADDR_WIDTH) and beat_cnt.
    - When beat_cnt reaches burst_len-1 on a transfer: decrement remaining[grant_col], set rr_ptr=grant_col.
      - If every remaining counter is now 0, go to FLUSH.
      - Otherwise go to PICK.
    - A granted column whose valid is low is never preempted; the grant is held.
  - FLUSH: wait until the output stage is empty (glb_wr_en==0 or accepted this cycle), then go to FIN.
  - FIN: pulse done for 1 cycle, then go to IDLE.
- Output stage:
  - Latency is 1 cycle from column handshake to glb_wr_en.
  - glb_wr_en stays high with data and addr stable until glb_wr_ready is seen.
  - Accept and drain in the same cycle gives full throughput of 1 beat/cycle.
- Masked-out columns always see ready 0.
- conf_en outside IDLE is ignored.
- rst mid-drain aborts the drain: the output stage is dropped and done is not pulsed.
- en low freezes everything, including the output stage, and forces psum_ready_out to 0.

Optional Feature:
- Macro PSUM_DRAIN_PERF_EN.
- Defined: perf_stall_cnt counts cycles in BURST/FLUSH where (valid[grant_col]==0) or (glb_wr_en && !glb_wr_ready). It saturates at 0xFFFF and clears on rst or on an accepted conf_en.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package: the state encoding (IDLE, PICK, BURST, FLUSH, FIN), the default BURST_WIDTH/ADDR_WIDTH constants, and the perf counter width 16.
- One combinational sub-module, rr_pick: inputs request vector and last pointer; outputs grant index and any_req.

Test Plan:
- COLS=4, mask=4'b1111, burst_len=3, bursts=2, base={0x300,0x200,0x100,0x000}, all valid=1, glb_wr_ready=1 -> grant order 1,2,3,0,1,2,3,0 (rr_ptr starts at 0); 24 writes; column 1 gets addrs 0x100-0x105; done pulses once.
- mask=4'b0101, burst_len=2, bursts=1 -> only columns 0 and 2 are granted; ready bits 1 and 3 stay 0 throughout; 4 writes.
- glb_wr_ready low for 5 cycles mid-burst -> glb_wr_en, addr and data held stable; ready_out is 0 during the stall; no beat lost or duplicated; with PSUM_DRAIN_PERF_EN, perf_stall_cnt=5.
- Granted column valid low for 10 cycles while other columns are valid -> grant not moved; burst resumes when valid returns.
- burst_len=0 -> done pulses 2 cycles after conf_en; no glb_wr_en.
- rst asserted during BURST, then reconfigured -> all outputs 0 the next cycle; the new drain starts from the fresh base_addr values.

Source files
------------

// File: rtl/psum_drain_arbiter_pkg.sv
// Shared types and default sizes for the psum drain arbiter.
// Cluster-level dimension macros fall back to standalone defaults when not supplied by the build.
`ifndef HWC_PE_CLUSTER_COLS
`define HWC_PE_CLUSTER_COLS 4
`endif
`ifndef HWC_PSUM_BUFFER_WIDTH
`define HWC_PSUM_BUFFER_WIDTH 16
`endif
`ifndef HWC_SIMD
`define HWC_SIMD 2
`endif

package psum_drain_arbiter_pkg;
    localparam int DEF_COLS        = `HWC_PE_CLUSTER_COLS;
    localparam int DEF_DATA_WIDTH  = `HWC_PSUM_BUFFER_WIDTH * `HWC_SIMD;
    localparam int DEF_BURST_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int PERF_WIDTH      = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_BURST = 3'd2,
        S_FLUSH = 3'd3,
        S_FIN   = 3'd4
    } state_t;
endpackage

// File: rtl/psum_drain_arbiter_rr_pick.sv
// Round-robin picker: first requesting column after i_last, wrapping, with i_last itself checked last.
// COLS is expected to be a power of two so index arithmetic wraps naturally.
module psum_drain_arbiter_rr_pick #(
    parameter int COLS = 4,
    localparam int IW  = $clog2(COLS)
) (
    input  logic [COLS-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_grant,
    output logic            o_any
);
    logic [IW-1:0]   w_cand [COLS];
    logic [COLS-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_cand
            assign w_cand[gi] = i_last + IW'(gi + 1);
            assign w_hit[gi]  = i_req[w_cand[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        o_grant = i_last;
        o_any   = |w_hit;
        for (int k = COLS - 1; k >= 0; k--) begin
            if (w_hit[k]) o_grant = w_cand[k];
        end
    end
endmodule

// File: rtl/psum_drain_arbiter.sv
// Drains per-column psum streams into one GLB write port, round-robin in fixed bursts.
// Optional stall counter enabled by defining PSUM_DRAIN_PERF_EN.
module psum_drain_arbiter
    import psum_drain_arbiter_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       conf_en,
    input  logic [COLS-1:0]            col_mask,
    input  logic [BURST_WIDTH-1:0]     burst_len,
    input  logic [BURST_WIDTH-1:0]     bursts_per_col,
    input  logic [COLS*ADDR_WIDTH-1:0] base_addr_packed,
    input  logic [COLS-1:0]            psum_valid_in,
    input  logic [COLS*DATA_WIDTH-1:0] psum_data_in_packed,
    output logic [COLS-1:0]            psum_ready_out,
    output logic                       glb_wr_en,
    output logic [ADDR_WIDTH-1:0]      glb_wr_addr,
    output logic [DATA_WIDTH-1:0]      glb_wr_data,
    input  logic                       glb_wr_ready,
    output logic [$clog2(COLS)-1:0]    grant_col,
    output logic                       busy,
    output logic                       done,
    output logic [PERF_WIDTH-1:0]      perf_stall_cnt
);
    localparam int IW = $clog2(COLS);

    state_t                 r_state;
    logic [IW-1:0]          r_rr_ptr;
    logic [IW-1:0]          r_grant;
    logic [ADDR_WIDTH-1:0]  r_addr [COLS];
    logic [BURST_WIDTH-1:0] r_rem  [COLS];
    logic [BURST_WIDTH-1:0] r_beat;
    logic [BURST_WIDTH-1:0] r_burst_len;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic                   r_done;

    logic [DATA_WIDTH-1:0]  w_data [COLS];
    logic [ADDR_WIDTH-1:0]  w_base [COLS];
    logic [COLS-1:0]        w_req;
    logic [COLS-1:0]        w_req_after;
    logic [IW-1:0]          w_pick;
    logic                   w_any;
    logic                   w_stage_free;
    logic                   w_ready_g;
    logic                   w_xfer;
    logic                   w_last_beat;
    logic                   w_cfg_empty;

    assign w_stage_free = !r_wr_en || glb_wr_ready;
    assign w_ready_g    = en && (r_state == S_BURST) && w_stage_free;
    assign w_xfer       = w_ready_g && psum_valid_in[r_grant];
    assign w_last_beat  = (r_beat == r_burst_len - 1'b1);
    assign w_cfg_empty  = (col_mask == '0) || (burst_len == '0) || (bursts_per_col == '0);

    // w_req_after is the request vector as it will look once the current burst retires.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            assign w_data[gi]         = psum_data_in_packed[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_base[gi]         = base_addr_packed[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_req[gi]          = (r_rem[gi] != '0);
            assign w_req_after[gi]    = (r_grant == IW'(gi)) ? (r_rem[gi] > BURST_WIDTH'(1)) : w_req[gi];
            assign psum_ready_out[gi] = w_ready_g && (r_grant == IW'(gi));
        end
    endgenerate

    psum_drain_arbiter_rr_pick #(.COLS(COLS)) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_rr_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_beat      <= '0;
            r_burst_len <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                r_addr[c] <= '0;
                r_rem[c]  <= '0;
            end
        end else if (en) begin
            r_done <= 1'b0;
            if (w_xfer) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr[r_grant];
                r_wr_data <= w_data[r_grant];
            end else if (glb_wr_ready) begin
                r_wr_en <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (conf_en) begin
                        r_burst_len <= burst_len;
                        for (int c = 0; c < COLS; c++) begin
                            if (col_mask[c]) begin
                                r_addr[c] <= w_base[c];
                                r_rem[c]  <= bursts_per_col;
                            end else begin
                                r_rem[c]  <= '0;
                            end
                        end
                        r_state <= w_cfg_empty ? S_FIN : S_PICK;
                    end
                end
                S_PICK: begin
                    r_grant <= w_pick;
                    r_beat  <= '0;
                    r_state <= w_any ? S_BURST : S_FLUSH;
                end
                S_BURST: begin
                    if (w_xfer) begin
                        r_addr[r_grant] <= r_addr[r_grant] + 1'b1;
                        r_beat          <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_rem[r_grant] <= r_rem[r_grant] - 1'b1;
                            r_rr_ptr       <= r_grant;
                            r_state        <= (|w_req_after) ? S_PICK : S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_stage_free) r_state <= S_FIN;
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign glb_wr_en   = r_wr_en;
    assign glb_wr_addr = r_wr_addr;
    assign glb_wr_data = r_wr_data;
    assign grant_col   = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;

`ifdef PSUM_DRAIN_PERF_EN
    logic [PERF_WIDTH-1:0] r_perf;
    logic                  w_stall;

    assign w_stall = ((r_state == S_BURST) || (r_state == S_FLUSH)) &&
                     (!psum_valid_in[r_grant] || (r_wr_en && !glb_wr_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (en) begin
            if ((r_state == S_IDLE) && conf_en) r_perf <= '0;
            else if (w_stall && (r_perf != '1)) r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_stall_cnt = r_perf;
`else
    assign perf_stall_cnt = '0;
`endif
endmodule
